hoop_round_ctrl: RTL and testbench
==================================

HOOP_ROUND_CTRL -- requirements
Module: hoop_round_ctrl

Interface
REQ-001 SHALL have parameter TICK_CYCLES, default 50000000, clock cycles per one-second tick.
REQ-002 SHALL have parameter ROUND_SECS, default 10, round length in seconds (1..255).
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 500000, cycles hoop input must be stable before acceptance.
REQ-004 SHALL have port: clock  in  1  system clock; all logic on rising edge.
REQ-005 SHALL have port: reset  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port: start  in  1  request to begin a round, level sampled per cycle.
REQ-007 SHALL have port: hoop_in  in  1  raw asynchronous hoop switch, high = ball present.
REQ-008 SHALL have port: time_left  out  8  seconds remaining in the current or next round.
REQ-009 SHALL have port: score  out  8  baskets counted in the current round.
REQ-010 SHALL have port: running  out  1  high while a round is in progress.
REQ-011 SHALL have port: commit  out  1  one-cycle pulse to the leaderboard at round end.
REQ-012 SHALL have port: final_score  out  8  score of the last completed round, held until the next commit.

Function
REQ-013 SHALL synchronise hoop_in through two flops before any other use.
REQ-014 SHALL update the debounced level only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the count.
REQ-015 SHALL generate one shot event on each 0->1 transition of the debounced level.
REQ-016 SHALL implement states IDLE, RUN, DONE; running = (state == RUN).
REQ-017 IDLE: start high -> RUN next cycle; score cleared to 0, time_left loaded with ROUND_SECS, prescaler cleared.
REQ-018 RUN: prescaler counts 0..TICK_CYCLES-1 and wraps; time_left decrements by 1 on each wrap cycle.
REQ-019 RUN: on the wrap cycle where time_left equals 1, time_left becomes 0 and state moves to DONE.
REQ-020 RUN: each shot event increments score by 1, saturating at 255.
REQ-021 A shot event coinciding with the final wrap cycle SHALL be counted and included in final_score.
REQ-022 DONE: commit = 1 for exactly this one cycle; final_score presents the score in the same cycle; next state IDLE.
REQ-023 Shot events in IDLE or DONE SHALL be ignored; score holds its last round value until the next start.
REQ-024 start SHALL be ignored in RUN and DONE; start held high across DONE begins a new round only from IDLE.
REQ-025 IDLE: time_left SHALL hold 0 after a completed round and ROUND_SECS after reset.
REQ-026 Counter widths SHALL be sized with $clog2 of their parameters; no arithmetic overflow except the defined prescaler wrap.

Reset
REQ-027 With reset low at a rising edge: state IDLE, time_left = ROUND_SECS, score = 0, final_score = 0, commit = 0, running = 0, prescaler = 0, debounce count = 0, debounced level = 0, sync flops = 0.
REQ-028 Reset low during RUN SHALL abort the round without a commit pulse.

Structure
REQ-029 Package hoop_pkg SHALL hold the state enumeration and the default values for TICK_CYCLES, ROUND_SECS, DEBOUNCE_CYCLES.
REQ-030 The synchroniser, debouncer and edge detector SHALL be one sub-module, hoop_debounce, outputting a one-cycle shot pulse.

Verification (TICK_CYCLES=4, ROUND_SECS=3, DEBOUNCE_CYCLES=2)
REQ-031 Reset, 1-cycle start pulse, no shots -> running high 12 cycles; time_left 3,2,1,0; commit single pulse with final_score = 0; then IDLE.
REQ-032 Three clean hoop pulses (high 4 cycles, low 4 cycles) during RUN -> score = 3; commit with final_score = 3.
REQ-033 Hoop glitch high 1 cycle -> no score change; glitch high 2 cycles after sync -> score +1.
REQ-034 300 shots in one round (large ROUND_SECS) -> score saturates at 255; final_score = 255.
REQ-035 Shot event on the final wrap cycle -> included; final_score = prior + 1; start held high through DONE -> new round begins from IDLE with score 0, time_left 3.
REQ-036 reset low mid-RUN -> next cycle IDLE, time_left = 3, score = 0, commit never asserted.

Source files
------------

// File: rtl/hoop_pkg.sv
// Shared types and default timing for the hoop round controller.
// The defaults assume a 50 MHz clock and a 10 ms switch debounce window.
package hoop_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int TICK_CYCLES_DEF     = 50000000;
    localparam int ROUND_SECS_DEF      = 10;
    localparam int DEBOUNCE_CYCLES_DEF = 500000;

    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/hoop_debounce.sv
// Two-flop synchroniser, debounce filter and rising-edge detector for the hoop switch.
// The shot pulse lasts one cycle and appears 2 + DEBOUNCE_CYCLES cycles after a clean rise; there is no backpressure.
module hoop_debounce
    import hoop_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic hoop_in,
    output logic shot
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          sync1;
    logic          sync2;
    logic          level;
    logic [CW-1:0] count;
    logic          differ;
    logic          accept;

    assign differ = (sync2 != level);
    assign accept = differ && (count == CW'(DEBOUNCE_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            level <= 1'b0;
            count <= '0;
            shot  <= 1'b0;
        end else begin
            sync1 <= hoop_in;
            sync2 <= sync1;
            shot  <= accept && sync2;
            // Any cycle where the input agrees with the filtered level restarts the window.
            if (!differ) begin
                count <= '0;
            end else if (accept) begin
                level <= sync2;
                count <= '0;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/hoop_round_ctrl.sv
// Timed basketball round: counts debounced shots for ROUND_SECS seconds, then pulses commit with the final score.
// Outputs are registered except running/commit, which decode the state; start is ignored outside IDLE.
module hoop_round_ctrl
    import hoop_pkg::*;
#(
    parameter int TICK_CYCLES     = TICK_CYCLES_DEF,
    parameter int ROUND_SECS      = ROUND_SECS_DEF,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       hoop_in,
    output logic [7:0] time_left,
    output logic [7:0] score,
    output logic       running,
    output logic       commit,
    output logic [7:0] final_score
);

    localparam int PW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;

    state_t        state;
    state_t        state_next;
    logic [PW-1:0] prescaler;
    logic          shot;
    logic          wrap;
    logic          last_tick;
    logic [7:0]    score_inc;

    hoop_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clock  (clock),
        .reset  (reset),
        .hoop_in(hoop_in),
        .shot   (shot)
    );

    assign wrap      = (prescaler == PW'(TICK_CYCLES - 1));
    assign last_tick = wrap && (time_left == 8'd1);
    assign score_inc = shot ? sat_inc8(score) : score;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        running    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                running = 1'b1;
                if (last_tick) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            time_left   <= 8'(ROUND_SECS);
            score       <= 8'd0;
            final_score <= 8'd0;
            prescaler   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        time_left <= 8'(ROUND_SECS);
                        score     <= 8'd0;
                        prescaler <= '0;
                    end
                end
                RUN: begin
                    score     <= score_inc;
                    prescaler <= wrap ? '0 : prescaler + PW'(1);
                    if (wrap) begin
                        time_left <= time_left - 8'd1;
                    end
                    // Capture includes a shot landing on the closing tick.
                    if (last_tick) begin
                        final_score <= score_inc;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hoop_round_ctrl.sv
// Bench for hoop_round_ctrl: short-round instance checked every cycle against a reference model,
// plus a long-round instance for multi-shot and saturation behaviour.
module tb_hoop_round_ctrl;

    localparam int TK  = 4;
    localparam int RS  = 3;
    localparam int DB  = 2;
    localparam int TKB = 16;
    localparam int RSB = 100;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset, start, hoop_in;
    logic [7:0] time_left, score, final_score;
    logic       running, commit;

    logic       reset_b, start_b, hoop_b;
    logic [7:0] time_left_b, score_b, final_b;
    logic       running_b, commit_b;

    hoop_round_ctrl #(.TICK_CYCLES(TK), .ROUND_SECS(RS), .DEBOUNCE_CYCLES(DB)) dut (
        .clock(clock), .reset(reset), .start(start), .hoop_in(hoop_in),
        .time_left(time_left), .score(score), .running(running),
        .commit(commit), .final_score(final_score)
    );

    hoop_round_ctrl #(.TICK_CYCLES(TKB), .ROUND_SECS(RSB), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clock(clock), .reset(reset_b), .start(start_b), .hoop_in(hoop_b),
        .time_left(time_left_b), .score(score_b), .running(running_b),
        .commit(commit_b), .final_score(final_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: round timing from elapsed RUN cycles, debounce from a window of synchronised samples.
    int m_el, m_score, m_final, m_idle_tl;
    bit m_run, m_done, m_lvl, m_shot;
    bit raw_hist[$];
    bit s2_hist[$];

    task automatic model_step();
        bit s2;
        bit all_diff;
        bit shot_now;
        if (!reset) begin
            m_run = 0; m_done = 0; m_score = 0; m_final = 0; m_idle_tl = RS;
            m_lvl = 0; m_shot = 0;
            raw_hist.delete();
            s2_hist.delete();
            return;
        end
        shot_now = m_shot;
        if (m_done) begin
            m_done = 0;
        end else if (m_run) begin
            if (shot_now && m_score < 255) m_score++;
            m_el++;
            if (m_el == RS * TK) begin
                m_run = 0; m_done = 1; m_final = m_score; m_idle_tl = 0;
            end
        end else if (start) begin
            m_run = 1; m_el = 0; m_score = 0;
        end
        s2 = (raw_hist.size() >= 2) ? raw_hist[raw_hist.size() - 2] : 1'b0;
        raw_hist.push_back(hoop_in);
        s2_hist.push_back(s2);
        if (raw_hist.size() > 8) void'(raw_hist.pop_front());
        if (s2_hist.size() > 8) void'(s2_hist.pop_front());
        m_shot = 0;
        if (s2_hist.size() >= DB) begin
            all_diff = 1;
            for (int i = 0; i < DB; i++)
                if (s2_hist[s2_hist.size() - 1 - i] == m_lvl) all_diff = 0;
            if (all_diff) begin
                m_lvl  = ~m_lvl;
                m_shot = m_lvl;
            end
        end
    endtask

    int run_cnt, com_cnt, com_final;

    task automatic tick();
        int exp_tl;
        @(posedge clock);
        model_step();
        @(negedge clock);
        exp_tl = m_run ? (RS - m_el / TK) : (m_done ? 0 : m_idle_tl);
        chk("time_left", time_left, exp_tl);
        chk("score", score, m_score);
        chk("running", running, m_run);
        chk("commit", commit, m_done);
        chk("final_score", final_score, m_final);
        run_cnt += running;
        if (commit) begin
            com_cnt++;
            com_final = final_score;
        end
    endtask

    task automatic clear_counts();
        run_cnt = 0; com_cnt = 0; com_final = -1;
    endtask

    task automatic wait_commit_b(input string tag);
        bit seen;
        seen = 0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            seen = commit_b;
        end
        chk(tag, seen, 1);
    endtask

    initial begin
        reset = 0; start = 0; hoop_in = 0;
        reset_b = 0; start_b = 0; hoop_b = 0;
        @(negedge clock);
        tick();
        tick();
        chk("rst_time_left", time_left, RS);
        chk("rst_score", score, 0);
        chk("rst_running", running, 0);
        chk("rst_commit", commit, 0);
        chk("rst_final", final_score, 0);
        chk("rst_b_time_left", time_left_b, RSB);
        chk("rst_b_running", running_b, 0);
        reset = 1; reset_b = 1;
        tick();

        // Plain round with no shots.
        clear_counts();
        start = 1; tick(); start = 0;
        repeat (20) tick();
        chk("s1_run_cycles", run_cnt, 12);
        chk("s1_commits", com_cnt, 1);
        chk("s1_final", com_final, 0);
        chk("s1_idle_tl", time_left, 0);

        // One-cycle glitch rejected, two-cycle pulse accepted.
        clear_counts();
        start = 1; tick(); start = 0;
        hoop_in = 1; tick(); hoop_in = 0;
        repeat (4) tick();
        chk("glitch1_score", score, 0);
        hoop_in = 1; repeat (2) tick(); hoop_in = 0;
        repeat (4) tick();
        chk("glitch2_score", score, 1);
        repeat (8) tick();
        chk("glitch_commits", com_cnt, 1);
        chk("glitch_final", com_final, 1);

        // Shot on the closing tick, start held through DONE.
        clear_counts();
        start = 1; tick();
        repeat (7) tick();
        hoop_in = 1;
        repeat (4) tick();
        chk("edge_score_pre", score, 0);
        hoop_in = 0;
        tick();
        chk("edge_commit", commit, 1);
        chk("edge_final", final_score, 1);
        tick();
        chk("edge_idle_running", running, 0);
        chk("edge_idle_score", score, 1);
        tick();
        chk("restart_running", running, 1);
        chk("restart_score", score, 0);
        chk("restart_tl", time_left, 3);
        start = 0;

        // Reset mid-round aborts without commit.
        repeat (3) tick();
        clear_counts();
        reset = 0; tick(); reset = 1;
        chk("abort_running", running, 0);
        chk("abort_tl", time_left, 3);
        chk("abort_score", score, 0);
        repeat (15) tick();
        chk("abort_commits", com_cnt, 0);

        // Long round: three clean pulses.
        start_b = 1; tick(); start_b = 0;
        repeat (3) begin
            hoop_b = 1; repeat (4) tick();
            hoop_b = 0; repeat (4) tick();
        end
        repeat (2) tick();
        chk("b_score3", score_b, 3);
        wait_commit_b("b_commit3_seen");
        chk("b_final3", final_b, 3);
        tick();
        chk("b_running_after", running_b, 0);

        // Long round: 300 shots saturate.
        start_b = 1; tick(); start_b = 0;
        repeat (300) begin
            hoop_b = 1; repeat (2) tick();
            hoop_b = 0; repeat (2) tick();
        end
        repeat (3) tick();
        chk("b_score_sat", score_b, 255);
        wait_commit_b("b_commit_sat_seen");
        chk("b_final_sat", final_b, 255);

        // Random traffic on the short-round instance.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            start = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 2) == 0) hoop_in = ~hoop_in;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
